// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID skid register.
package if_id_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } if_id_state_e;

  localparam logic [63:0] NOP_DEFAULT = 64'h0;
  localparam logic [7:0]  FLUSH_CNT_MAX = 8'hFF;

endpackage

// File: rtl/if_id_entry.sv
// One pipeline entry: valid bit plus PC/instruction, with load and clear.
module if_id_entry #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr
);

  logic               r_valid;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;

  // Clear wins over load so a flush can never leave a stale beat behind.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-deep skid so in_ready is a pure flop.
// state | meaning:  EMPTY | no beat held;  ONE | main holds a beat;  TWO | main and skid both hold beats
module if_id_skid_reg
  import if_id_pkg::*;
#(
  parameter int                  PC_W      = 8,
  parameter int                  INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(NOP_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [7:0]         flush_cnt
);

  if_id_state_e       r_state;
  if_id_state_e       w_state_nxt;
  logic               r_in_ready;
  logic [7:0]         r_flush_cnt;

  logic               w_accept;
  logic               w_drain;
  logic               w_main_load;
  logic               w_main_clr;
  logic               w_skid_load;
  logic               w_skid_clr;
  logic [PC_W-1:0]    w_main_d_pc;
  logic [INSTR_W-1:0] w_main_d_instr;

  logic               w_main_valid;
  logic [PC_W-1:0]    w_main_pc;
  logic [INSTR_W-1:0] w_main_instr;
  logic               w_skid_valid;
  logic [PC_W-1:0]    w_skid_pc;
  logic [INSTR_W-1:0] w_skid_instr;

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = out_valid && out_ready;

  // Main refills from skid whenever skid holds the older beat.
  assign w_main_d_pc    = w_skid_valid ? w_skid_pc    : in_pc;
  assign w_main_d_instr = w_skid_valid ? w_skid_instr : in_instr;

  always_comb begin
    w_state_nxt = r_state;
    w_main_load = 1'b0;
    w_main_clr  = 1'b0;
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ONE;
            w_main_load = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_drain) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = TWO;
            w_skid_load = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = EMPTY;
            w_main_clr  = 1'b1;
          end
        end
        TWO: begin
          if (w_drain) begin
            w_state_nxt = ONE;
            w_main_load = 1'b1;
            w_skid_clr  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_clr  = 1'b1;
          w_skid_clr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_cnt <= '0;
    end else if (flush && (r_state != EMPTY) && (r_flush_cnt != FLUSH_CNT_MAX)) begin
      r_flush_cnt <= r_flush_cnt + 8'd1;
    end
  end

  if_id_entry #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_main_clr),
    .i_load  (w_main_load),
    .i_pc    (w_main_d_pc),
    .i_instr (w_main_d_instr),
    .o_valid (w_main_valid),
    .o_pc    (w_main_pc),
    .o_instr (w_main_instr)
  );

  if_id_entry #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_skid_clr),
    .i_load  (w_skid_load),
    .i_pc    (in_pc),
    .i_instr (in_instr),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_pc    = (out_valid && w_main_valid) ? w_main_pc    : '0;
  assign out_instr = (out_valid && w_main_valid) ? w_main_instr : NOP_INSTR;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg; a queue model tracks held beats in FIFO order.
module tb_if_id_skid_reg;

  localparam int          PC_W    = 8;
  localparam int          INSTR_W = 32;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [7:0]         flush_cnt;

  if_id_skid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .flush_cnt (flush_cnt)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } beat_t;

  beat_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    m_cnt   = 0;
  bit    seen30  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [7:0] pc);
    return {24'hC0DE00, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, compare outputs mid-cycle against the model, then advance the model.
  task automatic step(input bit v, input logic [7:0] pc, input bit ordy, input bit fl, input bit rst);
    bit    acc;
    bit    drn;
    beat_t b;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #3;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_cnt));
    if (q.size() != 0) begin
      chk("out_pc", 64'(out_pc), 64'(q[0].pc));
      chk("out_instr", 64'(out_instr), 64'(q[0].instr));
    end else begin
      chk("idle_pc", 64'(out_pc), 64'd0);
      chk("idle_instr", 64'(out_instr), 64'(NOP));
    end
    if (out_valid === 1'b1 && ordy && out_pc === 8'h30) seen30 = 1;
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else if (fl) begin
      if (q.size() != 0 && m_cnt < 255) m_cnt++;
      q.delete();
    end else begin
      acc = v && (q.size() < 2);
      drn = (q.size() != 0) && ordy;
      if (drn) b = q.pop_front();
      if (acc) begin
        b.pc    = pc;
        b.instr = instr_of(pc);
        q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    step(0, 8'h00, 0, 0, 0);

    // streaming, one beat per cycle
    for (int i = 0; i < 5; i++) step(1, 8'h10 + 8'(i), 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // stall into TWO, offer a beat that must be refused, then release
    step(1, 8'h20, 0, 0, 0);
    step(1, 8'h21, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // flush in TWO while 0x30 is offered
    step(1, 8'h40, 0, 0, 0);
    step(1, 8'h41, 0, 0, 0);
    step(1, 8'h30, 0, 1, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // flush while empty does not count
    step(0, 8'h00, 1, 1, 0);
    step(0, 8'h00, 1, 0, 0);

    // accept+drain in ONE keeps streaming, then flush in ONE
    step(1, 8'h50, 0, 0, 0);
    step(1, 8'h51, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);

    // saturation
    for (int i = 0; i < 300; i++) begin
      step(1, 8'h60, 0, 0, 0);
      step(0, 8'h00, 0, 1, 0);
    end
    step(0, 8'h00, 0, 0, 0);
    chk("flush_sat", 64'(flush_cnt), 64'd255);

    // reset while in TWO, with flush and handshakes also active
    step(1, 8'h70, 0, 0, 0);
    step(1, 8'h71, 0, 0, 0);
    step(1, 8'h72, 1, 1, 1);
    step(1, 8'h80, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    chk("never_0x30", 64'(seen30), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have parameter NOP_INSTR, default all-zero INSTR_W, instruction driven whenever no valid beat is presented.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  fetch stage presents a beat.
REQ-007 SHALL have port in_ready  output  1  stage can accept a beat this cycle.
REQ-008 SHALL have port in_pc  input  PC_W  PC of fetched instruction.
REQ-009 SHALL have port in_instr  input  INSTR_W  fetched instruction.
REQ-010 SHALL have port flush  input  1  discard all held and incoming beats (branch redirect).
REQ-011 SHALL have port out_valid  output  1  decode beat valid.
REQ-012 SHALL have port out_ready  input  1  decode stage accepts beat.
REQ-013 SHALL have port out_pc  output  PC_W  PC of presented beat.
REQ-014 SHALL have port out_instr  output  INSTR_W  presented instruction.
REQ-015 SHALL have port flush_cnt  output  8  saturating count of flushes that discarded at least one valid beat.

Function
REQ-016 SHALL implement a 2-entry skid buffer: main entry drives outputs, skid entry absorbs one beat when decode stalls.
REQ-017 SHALL use states EMPTY, ONE, TWO, encoding occupancy 0/1/2.
REQ-018 SHALL accept a beat when in_valid and in_ready are both high, and drain when out_valid and out_ready are both high.
REQ-019 SHALL drive in_ready from a register, high exactly when state is not TWO (no combinational path from out_ready).
REQ-020 SHALL transition EMPTY->ONE on accept (main loads input); latency accept-to-out_valid 1 cycle.
REQ-021 SHALL in ONE: accept+drain -> ONE with main reloaded; accept only -> TWO with skid loaded; drain only -> EMPTY; neither -> hold.
REQ-022 SHALL in TWO: drain -> ONE with main loaded from skid; no drain -> hold; no accept possible.
REQ-023 SHALL sustain one beat per cycle when out_ready is held high, preserving strict FIFO order.
REQ-024 SHALL keep out_pc/out_instr stable while out_valid is high and out_ready is low.
REQ-025 SHALL drive out_valid = (state != EMPTY); when out_valid is low, out_instr = NOP_INSTR and out_pc = 0.
REQ-026 SHALL on flush go to EMPTY next cycle, invalidate both entries, drop any beat offered that cycle, and set in_ready high next cycle.
REQ-027 SHALL increment flush_cnt when flush is asserted with state != EMPTY, saturating at 255; flush has priority over accept and drain.

Reset
REQ-028 SHALL on reset force state EMPTY, out_valid 0, out_instr NOP_INSTR, out_pc 0, skid cleared, in_ready 1, flush_cnt 0.
REQ-029 SHALL let reset override flush and all handshakes, including mid-stall with TWO entries held.

Structure
REQ-030 SHALL place the state enum and default NOP constant in shared package if_id_pkg.
REQ-031 SHALL use one sub-module if_id_entry (valid+pc+instr register with load and clear) instantiated twice.

Verification
REQ-032 SHALL verify streaming: out_ready=1, beats pc 0x10..0x14 each cycle -> out_pc 0x10..0x14 one cycle later, no gaps.
REQ-033 SHALL verify stall: pc 0x20,0x21 accepted with out_ready=0 -> in_ready 0 in TWO, out_pc held 0x20; release -> 0x20 then 0x21.
REQ-034 SHALL verify flush in TWO with beat 0x30 offered -> next cycle out_valid 0, out_instr NOP, in_ready 1, flush_cnt 1, 0x30 never emitted.
REQ-035 SHALL verify flush_cnt saturation: 300 flushes with valid data held -> flush_cnt 255.
REQ-036 SHALL verify reset asserted in TWO -> all outputs at reset values next cycle; first beat after reset appears with latency 1.
